// File: rtl/expression_sequencer.sv
// Moore FSM sequencing the `operative` datapath through A*X^2 + B*X + C in Horner form.
// Optional build macro EXPR_OVF_ABORT_EN: an overflow in any ALU step ends the evaluation early.
module expression_sequencer #(
  parameter logic H_ADD     = 1'b0,
  parameter logic H_MUL     = 1'b1,
  parameter int   STEP_WAIT = 0,
  parameter int   WAIT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       overflow,
  output logic       LX,
  output logic       LS,
  output logic       LH,
  output logic       H,
  output logic [1:0] M0,
  output logic [1:0] M1,
  output logic [1:0] M2,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [2:0] {IDLE, LOAD, S1, S2, S3, S4, DONE} state_t;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(STEP_WAIT);

  state_t            state, state_nx;
  logic [WAIT_W-1:0] wait_cnt, wait_nx;
  logic              error_nx;
  logic              in_step;
  logic              last_cycle;

  assign in_step    = (state inside {S1, S2, S3, S4});
  assign last_cycle = in_step && (wait_cnt == WAIT_LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the simulator runs processes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      error    <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
      error    <= error_nx;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    wait_nx  = '0;
    error_nx = error;
    unique case (state)
      IDLE: if (start) begin
        state_nx = LOAD;
        error_nx = 1'b0;
      end
      LOAD: state_nx = S1;
      S1, S2, S3, S4: begin
        if (!last_cycle) begin
          wait_nx = wait_cnt + 1'b1;
        end else begin
          unique case (state)
            S1:      state_nx = S2;
            S2:      state_nx = S3;
            S3:      state_nx = S4;
            default: state_nx = DONE;
          endcase
        end
      end
      DONE: if (!start) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    // Overflow only matters on the cycle the step's result is written back.
    if (last_cycle && overflow) begin
      error_nx = 1'b1;
`ifdef EXPR_OVF_ABORT_EN
      state_nx = DONE;
      wait_nx  = '0;
`endif
    end
  end

  always_comb begin
    LX   = 1'b0;
    LS   = 1'b0;
    LH   = 1'b0;
    H    = H_ADD;
    M0   = 2'd0;
    M1   = 2'd0;
    M2   = 2'd0;
    busy = (state != IDLE);
    done = (state == DONE);
    unique case (state)
      LOAD: LX = 1'b1;
      S1: begin  // S = A*X
        M0 = 2'd1; M1 = 2'd1; M2 = 2'd1; H = H_MUL; LS = last_cycle;
      end
      S2: begin  // S = S+B
        M0 = 2'd2; M1 = 2'd0; M2 = 2'd2; H = H_ADD; LS = last_cycle;
      end
      S3: begin  // S = S*X
        M0 = 2'd0; M1 = 2'd1; M2 = 2'd2; H = H_MUL; LS = last_cycle;
      end
      S4: begin  // Hreg = S+C
        M0 = 2'd3; M1 = 2'd0; M2 = 2'd2; H = H_ADD; LH = last_cycle;
      end
      default: ;
    endcase
  end

endmodule
